// File: rtl/hp_bar_controller_if.sv
// Scan/ROM bus for the HP bar sequencer.
//   DrawX, DrawY   : VGA scan position (driven by the video timing side)
//   rom_address    : read address into the HP sprite ROM
//   hp_pixel_valid : ROM data this cycle is an HP-bar pixel to draw
// master = the HP bar controller, slave = scan source / ROM / colour mapper.
interface hp_bar_controller_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [14:0] rom_address;
  logic        hp_pixel_valid;

  modport master (
    input  DrawX,
    input  DrawY,
    output rom_address,
    output hp_pixel_valid
  );

  modport slave (
    output DrawX,
    output DrawY,
    input  rom_address,
    input  hp_pixel_valid
  );
endinterface

// File: rtl/hp_bar_controller.sv
// HP bar sequencer: owns lives, the post-hit invulnerability window, the blink
// effect and game-over, and turns the scan position into a sprite ROM address
// inside the 3072-word frame selected by the displayed lives count.
// Ports:
//   Clk, Reset      : clock, synchronous active-high reset
//   frame_tick      : one-cycle pulse at start of vertical blank
//   hit, restart    : one-cycle damage / restore-lives pulses
//   bus (master)    : DrawX/DrawY in, rom_address/hp_pixel_valid out
//   lives           : current lives count (0..5)
//   invuln          : invulnerability window open
//   game_over       : lives reached zero
module hp_bar_controller #(
  parameter logic [9:0]  HP_X0         = 10'd8,
  parameter logic [9:0]  HP_Y0         = 10'd8,
  parameter int unsigned SPR_W         = 96,
  parameter int unsigned SPR_H         = 32,
  parameter int unsigned INVULN_FRAMES = 120
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_tick,
  input  logic                 hit,
  input  logic                 restart,
  hp_bar_controller_if.master  bus,
  output logic [2:0]           lives,
  output logic                 invuln,
  output logic                 game_over
);

  localparam int unsigned InvCntW    = $clog2(INVULN_FRAMES + 1);
  localparam logic [10:0] XLo        = {1'b0, HP_X0};
  localparam logic [10:0] XHi        = XLo + 11'(SPR_W);
  localparam logic [10:0] YLo        = {1'b0, HP_Y0};
  localparam logic [10:0] YHi        = YLo + 11'(SPR_H);
  localparam logic [14:0] FrameWords = 15'(SPR_W * SPR_H);
  localparam logic [14:0] SprW15     = 15'(SPR_W);
  localparam logic [2:0]  MaxLives   = 3'd5;

  typedef enum logic [1:0] {StAlive, StInvuln, StDead} state_e;

  state_e               state_q, state_d;
  logic [2:0]           lives_q, lives_d;
  logic [InvCntW-1:0]   inv_cnt_q, inv_cnt_d;
  logic [2:0]           shown_q, shown_d;
  logic                 blink_q, blink_d;
  logic [14:0]          addr_q, addr_d;
  logic [1:0]           vld_q;

  logic [10:0] x11, y11, dx, dy;
  logic        in_region;
  logic [2:0]  shown_eff;
  logic [14:0] base;

  // Life-state FSM and frame-synchronous display latch.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    inv_cnt_d = inv_cnt_q;
    shown_d   = shown_q;
    blink_d   = blink_q;

    // Display values only move on frame_tick so the bar never tears mid-frame.
    if (frame_tick) begin
      shown_d = lives_q;
      blink_d = (state_q == StInvuln) & inv_cnt_q[2];
    end

    case (state_q)
      StAlive: begin
        if (hit) begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_d = StDead;
          end else begin
            state_d   = StInvuln;
            inv_cnt_d = InvCntW'(INVULN_FRAMES);
          end
        end
      end
      StInvuln: begin
        if (frame_tick) begin
          if (inv_cnt_q == InvCntW'(1)) begin
            state_d   = StAlive;
            inv_cnt_d = '0;
          end else begin
            inv_cnt_d = inv_cnt_q - InvCntW'(1);
          end
        end
      end
      StDead: ;
      default: state_d = StAlive;
    endcase

    if (restart) begin
      state_d   = StAlive;
      lives_d   = MaxLives;
      inv_cnt_d = '0;
      shown_d   = MaxLives;
      blink_d   = 1'b0;
    end
  end

  // Address generation. restart forces the full-lives frame on the same edge.
  always_comb begin
    x11       = {1'b0, bus.DrawX};
    y11       = {1'b0, bus.DrawY};
    in_region = (x11 >= XLo) && (x11 < XHi) && (y11 >= YLo) && (y11 < YHi);
    dx        = x11 - XLo;
    dy        = y11 - YLo;
    shown_eff = restart ? MaxLives : shown_q;
    base      = 15'(MaxLives - shown_eff) * FrameWords;
    addr_d    = base;
    if (in_region) begin
      addr_d = base + 15'(dy) * SprW15 + 15'(dx);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StAlive;
      lives_q   <= MaxLives;
      inv_cnt_q <= '0;
      shown_q   <= MaxLives;
      blink_q   <= 1'b0;
      addr_q    <= '0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      inv_cnt_q <= inv_cnt_d;
      shown_q   <= shown_d;
      blink_q   <= blink_d;
      addr_q    <= addr_d;
      // Stage 0 pairs the region hit with the blink state of the same pixel;
      // stage 1 lines it up with the ROM's registered data.
      vld_q     <= {vld_q[0], in_region & ~blink_q};
    end
  end

  assign bus.rom_address    = addr_q;
  assign bus.hp_pixel_valid = vld_q[1];
  assign lives              = lives_q;
  assign invuln             = (state_q == StInvuln);
  assign game_over          = (state_q == StDead);

endmodule
